// File: rtl/dram_ctrl.sv
// Single-port DRAM command sequencer: one word access per handshake, keeps one
// row open between accesses, and drives registered ACT/READ/WRITE/PRE pin cycles.
module dram_ctrl #(
  parameter int TRCD = 2,
  parameter int TRP  = 2,
  parameter int TWR  = 2
) (
  input  logic        dram_clk,
  input  logic        dram_rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [20:0] req_addr,
  input  logic [3:0]  req_wstrb,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        DRAM_CSn,
  output logic        DRAM_RASn,
  output logic        DRAM_CASn,
  output logic [3:0]  DRAM_WEn,
  output logic [10:0] DRAM_A,
  output logic [31:0] DRAM_D,
  input  logic [31:0] DRAM_Q,
  input  logic        DRAM_valid
);

  // state | meaning
  // IDLE no row open | OPEN row open | PRE/PRE_WAIT closing | ACT/ACT_WAIT opening
  // CAS column command | RD_WAIT waiting for DRAM_valid | WR_WAIT write recovery
  typedef enum logic [3:0] {
    S_IDLE, S_OPEN, S_PRE, S_PRE_WAIT, S_ACT, S_ACT_WAIT, S_CAS, S_RD_WAIT, S_WR_WAIT
  } state_e;

  localparam logic [3:0] TRCD_M1 = 4'(TRCD - 1);
  localparam logic [3:0] TRP_M1  = 4'(TRP - 1);
  localparam logic [3:0] TWR_M1  = 4'(TWR - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [10:0] open_row_q, open_row_d;
  logic        row_vld_q, row_vld_d;

  logic        wr_q;
  logic [20:0] addr_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;

  logic        csn_q, csn_d, rasn_q, rasn_d, casn_q, casn_d;
  logic [3:0]  wen_q, wen_d;
  logic [10:0] a_q, a_d;
  logic [31:0] d_q, d_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rdata_q, rdata_d;

  logic        accept;
  logic        eff_write;
  logic [20:0] eff_addr;
  logic [3:0]  eff_wstrb;
  logic [31:0] eff_wdata;

  assign req_ready = (state_q == S_IDLE) || (state_q == S_OPEN);
  assign accept    = req_valid && req_ready;

  // Pins are registered from state_d, so a request accepted this edge must
  // drive its command from the live request fields, not the latches.
  assign eff_write = accept ? req_write : wr_q;
  assign eff_addr  = accept ? req_addr  : addr_q;
  assign eff_wstrb = accept ? req_wstrb : wstrb_q;
  assign eff_wdata = accept ? req_wdata : wdata_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    open_row_d  = open_row_q;
    row_vld_d   = row_vld_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    case (state_q)
      S_IDLE: if (accept) state_d = S_ACT;
      S_OPEN: begin
        if (accept) begin
          if (row_vld_q && (req_addr[20:10] == open_row_q)) state_d = S_CAS;
          else                                              state_d = S_PRE;
        end
      end
      S_PRE: begin
        state_d = S_PRE_WAIT;
        cnt_d   = TRP_M1;
      end
      S_PRE_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_ACT;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ACT: begin
        state_d    = S_ACT_WAIT;
        cnt_d      = TRCD_M1;
        open_row_d = addr_q[20:10];
        row_vld_d  = 1'b1;
      end
      S_ACT_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_CAS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_CAS: begin
        if (wr_q) begin
          state_d = S_WR_WAIT;
          cnt_d   = TWR_M1;
        end else begin
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (DRAM_valid) begin
          state_d     = S_OPEN;
          rsp_valid_d = 1'b1;
          rdata_d     = DRAM_Q;
        end
      end
      S_WR_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d     = S_OPEN;
          rsp_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    csn_d  = 1'b0;
    rasn_d = 1'b1;
    casn_d = 1'b1;
    wen_d  = 4'hF;
    a_d    = 11'd0;
    d_d    = 32'd0;
    case (state_d)
      S_IDLE: csn_d = 1'b1;
      S_ACT: begin
        rasn_d = 1'b0;
        a_d    = eff_addr[20:10];
      end
      S_PRE: begin
        rasn_d = 1'b0;
        wen_d  = 4'h0;
      end
      S_CAS: begin
        casn_d = 1'b0;
        a_d    = {1'b0, eff_addr[9:0]};
        if (eff_write) begin
          wen_d = ~eff_wstrb;
          d_d   = eff_wdata;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge dram_clk or negedge dram_rst) begin
    if (!dram_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      open_row_q  <= 11'd0;
      row_vld_q   <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= 21'd0;
      wstrb_q     <= 4'd0;
      wdata_q     <= 32'd0;
      csn_q       <= 1'b1;
      rasn_q      <= 1'b1;
      casn_q      <= 1'b1;
      wen_q       <= 4'hF;
      a_q         <= 11'd0;
      d_q         <= 32'd0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      open_row_q  <= open_row_d;
      row_vld_q   <= row_vld_d;
      csn_q       <= csn_d;
      rasn_q      <= rasn_d;
      casn_q      <= casn_d;
      wen_q       <= wen_d;
      a_q         <= a_d;
      d_q         <= d_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wstrb_q <= req_wstrb;
        wdata_q <= req_wdata;
      end
    end
  end

  assign DRAM_CSn  = csn_q;
  assign DRAM_RASn = rasn_q;
  assign DRAM_CASn = casn_q;
  assign DRAM_WEn  = wen_q;
  assign DRAM_A    = a_q;
  assign DRAM_D    = d_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_dram_ctrl.sv
// Bench for dram_ctrl: table of accesses with hand-derived pin timing, a read-data
// scoreboard, plus back-to-back and mid-access reset sequences.
module tb_dram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [20:0] req_addr = '0;
  logic [3:0]  req_wstrb = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        csn, rasn, casn;
  logic [3:0]  wen;
  logic [10:0] a;
  logic [31:0] d, q = '0;
  logic        dvalid = 1'b0;

  dram_ctrl dut (
    .dram_clk(clk), .dram_rst(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wstrb(req_wstrb), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .DRAM_CSn(csn), .DRAM_RASn(rasn), .DRAM_CASn(casn), .DRAM_WEn(wen),
    .DRAM_A(a), .DRAM_D(d), .DRAM_Q(q), .DRAM_valid(dvalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [20:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] q;
    int          qdly;
    int          e_pre, e_act, e_cas, e_rsp;
  } vec_t;

  int tests = 0, fails = 0;
  logic [31:0] sb[$];
  logic [31:0] m_rdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pop_chk(input string name);
    logic [31:0] e;
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk(name, rsp_rdata, e);
    end
  endtask

  function automatic bit is_pre();
    return !csn && !rasn && casn && (wen == 4'h0);
  endfunction
  function automatic bit is_act();
    return !csn && !rasn && casn && (wen == 4'hF);
  endfunction
  function automatic bit is_cas();
    return !csn && rasn && !casn;
  endfunction

  task automatic do_access(input vec_t v, input string tag);
    int pre_c, act_c, cas_c, rsp_c;
    logic [10:0] act_a, cas_a;
    logic [3:0]  cas_we;
    logic [31:0] cas_d;
    pre_c = -1; act_c = -1; cas_c = -1; rsp_c = -1;
    act_a = '0; cas_a = '0; cas_we = '0; cas_d = '0;
    if (!v.write) m_rdata = v.q;
    sb.push_back(m_rdata);
    @(negedge clk);
    chk({tag, "_ready_idle"}, {31'd0, req_ready}, 32'd1);
    chk({tag, "_no_stray_rsp"}, {31'd0, rsp_valid}, 32'd0);
    req_valid = 1'b1; req_write = v.write; req_addr = v.addr;
    req_wstrb = v.wstrb; req_wdata = v.wdata;
    @(posedge clk);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (is_pre() && pre_c < 0) pre_c = k;
      if (is_act() && act_c < 0) begin act_c = k; act_a = a; end
      if (is_cas() && cas_c < 0) begin cas_c = k; cas_a = a; cas_we = wen; cas_d = d; end
      if (rsp_valid) begin
        rsp_c = k;
        pop_chk({tag, "_rdata"});
        chk({tag, "_ready_at_rsp"}, {31'd0, req_ready}, 32'd1);
        break;
      end
      // DRAM_valid pulses outside RD_WAIT carry junk that must be ignored
      if (v.write) begin
        dvalid = 1'b1; q = $urandom;
      end else if (cas_c > 0 && k == cas_c + v.qdly) begin
        dvalid = 1'b1; q = v.q;
      end else if (cas_c > 0 && k == cas_c) begin
        dvalid = 1'b1; q = $urandom;
      end else begin
        dvalid = 1'b0; q = $urandom;
      end
    end
    dvalid = 1'b0;
    chk({tag, "_pre_cycle"}, pre_c, v.e_pre);
    chk({tag, "_act_cycle"}, act_c, v.e_act);
    if (v.e_act > 0) chk({tag, "_act_row"}, {21'd0, act_a}, {21'd0, v.addr[20:10]});
    chk({tag, "_cas_cycle"}, cas_c, v.e_cas);
    chk({tag, "_cas_col"}, {21'd0, cas_a}, {22'd0, v.addr[9:0]});
    chk({tag, "_cas_wen"}, {28'd0, cas_we}, {28'd0, v.write ? ~v.wstrb : 4'hF});
    if (v.write) chk({tag, "_cas_d"}, cas_d, v.wdata);
    chk({tag, "_rsp_cycle"}, rsp_c, v.e_rsp);
  endtask

  task automatic chk_reset_pins(input string tag);
    chk({tag, "_csn"}, {31'd0, csn}, 32'd1);
    chk({tag, "_rasn_casn"}, {30'd0, rasn, casn}, 32'd3);
    chk({tag, "_wen"}, {28'd0, wen}, 32'hF);
    chk({tag, "_a_d"}, {21'd0, a} | d, 32'd0);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  vec_t tbl[7];
  vec_t v8;

  initial begin
    int cas1, rsp1, cas2, rsp2;
    tbl[0] = '{1'b0, 21'h000C05, 4'h0, 32'h0,        32'hDEADBEEF, 3, -1, 1, 4, 8};
    tbl[1] = '{1'b1, 21'h000C09, 4'h5, 32'h11223344, 32'h0,        0, -1,-1, 1, 4};
    tbl[2] = '{1'b0, 21'h001C12, 4'h0, 32'h0,        32'hCAFEF00D, 1,  1, 4, 7, 9};
    tbl[3] = '{1'b1, 21'h001FFF, 4'hF, 32'hA5A55A5A, 32'h0,        0, -1,-1, 1, 4};
    tbl[4] = '{1'b0, 21'h1FFC00, 4'h0, 32'h0,        32'h0F0F0F0F, 1,  1, 4, 7, 9};
    tbl[5] = '{1'b1, 21'h000200, 4'h8, 32'h87654321, 32'h0,        0,  1, 4, 7, 10};
    tbl[6] = '{1'b0, 21'h0003FF, 4'h0, 32'h0,        32'h13579BDF, 5, -1,-1, 1, 7};
    v8     = '{1'b0, 21'h001401, 4'h0, 32'h0,        32'h24681357, 2, -1, 1, 4, 7};

    repeat (3) @(negedge clk);
    chk_reset_pins("reset");
    rst_n = 1'b1;

    foreach (tbl[i]) do_access(tbl[i], $sformatf("vec%0d", i));

    // back-to-back: second request waits through the first read's response
    sb.push_back(32'hA1B2C3D4);
    sb.push_back(32'h5566AA99);
    m_rdata = 32'h5566AA99;
    cas1 = -1; rsp1 = -1; cas2 = -1; rsp2 = -1;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 21'h000021;
    @(posedge clk);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      req_addr = 21'h000022;
      if (is_cas() && cas1 < 0) cas1 = k;
      if (rsp_valid) begin
        rsp1 = k;
        pop_chk("b2b_rdata1");
        chk("b2b_ready_at_rsp", {31'd0, req_ready}, 32'd1);
        break;
      end
      dvalid = (cas1 > 0 && k == cas1 + 2);
      q = dvalid ? 32'hA1B2C3D4 : $urandom;
    end
    dvalid = 1'b0;
    chk("b2b_cas1", cas1, 1);
    chk("b2b_rsp1", rsp1, 4);
    for (int k = rsp1 + 1; k <= rsp1 + 30; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (is_cas() && cas2 < 0) begin
        cas2 = k;
        chk("b2b_cas2_col", {21'd0, a}, 32'h22);
      end
      if (rsp_valid) begin
        rsp2 = k;
        pop_chk("b2b_rdata2");
        break;
      end
      dvalid = (cas2 > 0 && k == cas2 + 1);
      q = dvalid ? 32'h5566AA99 : $urandom;
    end
    dvalid = 1'b0;
    chk("b2b_cas2_cycle", cas2, rsp1 + 1);
    chk("b2b_rsp2_cycle", rsp2, rsp1 + 3);

    // reset in the second ACT_WAIT cycle of a row miss (row 0 open, go to row 5)
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 21'h001401;
    @(posedge clk);
    cas1 = -1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (is_act() && cas1 < 0) cas1 = k;
    end
    chk("rst_mid_act_seen", cas1, 4);
    rst_n = 1'b0;
    #1;
    chk_reset_pins("rst_mid");
    rsp1 = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (rsp_valid) rsp1++;
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (rsp_valid) rsp1++;
    end
    chk("rst_mid_no_rsp", rsp1, 0);
    m_rdata = 32'd0;
    do_access(v8, "after_rst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
